sigmul_iter: RTL and testbench

Iterative radix-2 shift-add significand multiplier, a sequential alternative to the combinational half/full-adder array.
- Consumes unpacked significands with the hidden bit included and produces the full double-width product.
- Output feeds the normalize/round stage.
- One adder row, reused for NSIG+1 cycles.
- Valid/ready on both sides.

---
 rtl/sigmul_iter.sv | 114 +++++++++++
 tb/tb_sigmul_iter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sigmul_iter.sv
// sigmul_iter: iterative radix-2 shift-add significand multiplier.
// Takes two NSIG+1-bit significands (hidden bit at MSB) and returns the exact
// 2*NSIG+2-bit product. A single NSIG+2-bit adder row is reused for NSIG+1
// iterations, with one iteration per clock.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// in_ready is high only in IDLE, so operands are sampled only on the accept
// edge. Once out_valid rises it stays high, with p frozen, until a rising edge
// that sees out_ready high. A new accept is never taken on that same edge.
//
// Optional build macro SIGMUL_ZERO_SKIP_EN: when defined, a zero operand skips
// the iteration phase and the block goes straight from IDLE to DONE with p = 0.
module sigmul_iter #(
  parameter int NSIG = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NSIG:0]       a,
  input  logic [NSIG:0]       b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*NSIG+1:0]   p,
  output logic                busy
);

  localparam int W  = NSIG + 1;          // operand width
  localparam int HW = NSIG + 2;          // hi half of P, holds the adder carry
  localparam int PW = 2 * NSIG + 3;      // full partial-product register
  localparam int CW = $clog2(NSIG + 1);  // iteration counter width
  localparam logic [CW-1:0] CNT_LAST = CW'(NSIG);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // state is the observable FSM state for debug and checker binding
  state_t            state;
  state_t            state_nxt;
  logic [NSIG:0]     mcand;
  logic [PW-1:0]     prod;
  logic [CW-1:0]     cnt;
  logic [2*NSIG+1:0] p_q;
  logic [HW-1:0]     hi_sum;
  logic [PW-1:0]     prod_step;
  logic              skip;

`ifdef SIGMUL_ZERO_SKIP_EN
  assign skip = (a == '0) || (b == '0);
`else
  assign skip = 1'b0;
`endif

  // One shift-add step: conditionally add the multiplicand into the hi row,
  // then shift the whole register right, pulling the carry into the top.
  always_comb begin
    hi_sum    = prod[PW-1:W] + (prod[0] ? {1'b0, mcand} : {HW{1'b0}});
    prod_step = {hi_sum, prod[W-1:0]} >> 1;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = skip ? DONE : RUN;
      RUN:  if (cnt == CNT_LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load operands on accept, iterate in RUN, latch p on the last step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
      p_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= a;
            cnt   <= '0;
            if (skip) begin
              prod <= '0;
              p_q  <= '0;
            end else begin
              prod <= {{HW{1'b0}}, b};
            end
          end
        end
        RUN: begin
          prod <= prod_step;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) p_q <= prod_step[2*NSIG+1:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign p         = p_q;

endmodule

// File: tb/tb_sigmul_iter.sv
// Bench for sigmul_iter: directed test-plan cases followed by randomized
// operands, with a reference product model built from plain multiplication.
// An expected queue tracks accepted operands against delivered results.
module tb_sigmul_iter;

  localparam int NSIG = 10;
  localparam int W    = NSIG + 1;
  localparam int PWO  = 2 * NSIG + 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [PWO-1:0] p;
  logic           busy;

  int checks   = 0;
  int failures = 0;
  int accepted = 0;
  int results  = 0;
  logic [PWO-1:0] exp_q[$];

  sigmul_iter #(.NSIG(NSIG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // reference model: exact unsigned product
  function automatic logic [PWO-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    return PWO'(x) * PWO'(y);
  endfunction

  // cycles from the accept edge until out_valid is seen
  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SIGMUL_ZERO_SKIP_EN
    if (x == '0 || y == '0) return 0;
`endif
    return NSIG + 1;
  endfunction

  // noise while busy: 0 none, 1 random in_valid/a/b, 2 fixed a=b=11'h400 valid
  task automatic drive_noise(input int mode);
    if (mode == 1) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
    end else if (mode == 2) begin
      in_valid = 1'b1;
      a = 11'h400;
      b = 11'h400;
    end
  endtask

  // One full transaction: present operands, check latency, hold for `hold`
  // cycles with out_ready low (hold=0 keeps out_ready high), then consume.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input int hold, input int noise);
    int lat;
    logic [PWO-1:0] e;
    @(negedge clk);
    a = ta; b = tb_v; in_valid = 1'b1;
    out_ready = (hold == 0);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back(model(ta, tb_v));
    accepted++;
    #1;
    in_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      drive_noise(noise);
      @(posedge clk);
      lat++;
      #1;
    end
    check("latency", 32'(lat), 32'(exp_lat(ta, tb_v)));
    if (out_valid !== 1'b1) begin
      $display("FAIL out_valid_timeout observed=0 expected=1");
      failures++;
      return;
    end
    e = exp_q[0];
    check("p_value", 32'(p), 32'(e));
    check("in_ready_in_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      drive_noise(noise);
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_p_stable", 32'(p), 32'(e));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    void'(exp_q.pop_front());
    results++;
    check("after_consume_out_valid", 32'(out_valid), 32'd0);
    check("after_consume_in_ready", 32'(in_ready), 32'd1);
    check("after_consume_p_held", 32'(p), 32'(e));
  endtask

  initial begin
    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_p", 32'(p), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    run_op(11'h400, 11'h400, 0, 0);
    run_op(11'h7FF, 11'h7FF, 0, 0);
    run_op(11'h5A5, 11'h4C3, 5, 2);
    // nothing extra may come out after the ignored second request
    repeat (3) begin
      @(posedge clk); #1;
      check("no_duplicate_out_valid", 32'(out_valid), 32'd0);
    end

    // abort mid-run with an asynchronous reset
    @(negedge clk);
    a = 11'h7FF; b = 11'h7FF; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_p", 32'(p), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(11'h600, 11'h600, 0, 0);

    // zero operand
    run_op(11'h000, 11'h5A5, 0, 0);
    run_op(11'h5A5, 11'h000, 2, 1);

    // randomized operands with hidden bit set, gaps and back-pressure
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      ra = {1'b1, 10'($urandom_range(0, 1023))};
      rb = {1'b1, 10'($urandom_range(0, 1023))};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(ra, rb, $urandom_range(0, 3), 1);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("results_match_accepts", 32'(results), 32'(accepted));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
